gray_req_arbiter: RTL
=====================

# gray_req_arbiter

Shares one 4-bit binary-to-Gray converter (`bin2gray_4bit`) between two requesters behind valid/ready handshakes. It arbitrates round-robin, sequences the converter through a three-state FSM, and registers the Gray result with the ID of the requester that was served. It sits between the two producer blocks and the shared conversion datapath. It also keeps per-requester saturating service counters for debug.

## Interface
Parameters:
- `WIDTH`, 4, operand/result width; only 4 is supported because it matches the converter.
- `CNT_W`, 8, width of the service counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0_valid`  in  1  requester 0 has an operand.
- `req0_bin`  in  WIDTH  requester 0 binary operand.
- `req0_ready`  out  1  requester 0 operand accepted this cycle.
- `req1_valid`, `req1_bin`, `req1_ready`: same as requester 0, for requester 1.
- `out_valid`  out  1  result available.
- `out_gray`  out  WIDTH  Gray-coded result.
- `out_id`  out  1  ID of the requester that owns the result.
- `out_ready`  in  1  consumer takes the result.
- `busy`  out  1  FSM is not in IDLE.
- `cnt0`, `cnt1`  out  CNT_W  completed transfers per requester, saturating.
- `err`  out  1  sticky self-check error (see Configuration).

## Operation
FSM states and transitions:
- IDLE: if any `reqN_valid`, grant one requester (see arbitration). Assert that requester's `reqN_ready` combinationally, latch its operand and ID, then go to CONV. With no requests, stay in IDLE.
- CONV: the latched operand drives the converter. Register `out_gray = b ^ (b >> 1)` and go to HOLD.
- HOLD: `out_valid`=1 and outputs are stable. On `out_ready`=1: increment the served requester's counter (saturating at 2^CNT_W-1), update the last-grant pointer, and go to IDLE. Otherwise stay in HOLD.

Arbitration rules:
- Round-robin over two requesters. When both are valid, grant the requester that was not served last.
- After reset the pointer favours requester 0.
- A single valid requester is always granted, whatever the pointer.

Handshake rules:
- `reqN_ready` is high only in IDLE, only for the granted requester, and only while its `reqN_valid` is high. Both ready signals are never high together.
- A requester dropping `valid` after acceptance has no effect; the operand is already latched.
- `out_gray` and `out_id` are held while `out_valid`=1 and `out_ready`=0.

Reset behaviour:
- `rst` at any time (including mid-CONV/HOLD) forces IDLE and clears these outputs: `out_valid`=0, `out_gray`=0, `out_id`=0, `busy`=0, `cnt0`=`cnt1`=0, `err`=0, both `ready`=0.
- The pointer is reset to favour requester 0.
- An in-flight operand is discarded.

## Timing
- Acceptance handshake at edge E (IDLE). The FSM is in CONV after E and in HOLD with `out_valid`=1 after E+1. Latency from accept to result is 2 cycles.
- With `out_ready` tied high, one transfer completes every 3 cycles. Peak throughput is 1/3.
- Counter and pointer update on the same edge as the output handshake. The counter value is visible the cycle after.
- `busy` is registered, equal to state != IDLE.

## Configuration
`GRAY_SELFCHECK_EN` controls the self-check.
- When defined: a `gray2bin_4bit` inverse is instantiated on the converter output in CONV. If its result differs from the latched operand, `err` sets on the CONV→HOLD edge and stays set until `rst`.
- When undefined: no inverse logic is built and `err` is tied 0.

## Structure
- Shared package `gray_pkg` holds:
  - the `WIDTH` default constant;
  - the FSM state enum (IDLE, CONV, HOLD);
  - the requester ID constants (`REQ0`=0, `REQ1`=1).
- The existing `bin2gray_4bit` is instantiated as the shared datapath, with no changes to it.
- `gray2bin_4bit` is the one natural new sub-module, instantiated only under `GRAY_SELFCHECK_EN`.

## Test plan
- Reset mid-HOLD, then release: all outputs are 0 and the FSM is in IDLE. A subsequent simultaneous request is granted to requester 0.
- Requester 0 alone sends 0101 with `out_ready`=1: `req0_ready` pulses once, and 2 cycles later `out_valid`=1, `out_gray`=0111, `out_id`=0. After that, `cnt0`=1.
- Both requesters valid continuously, 1111 (req0) and 1010 (req1): results alternate 1000/id0, 1111/id1, 1000/id0, and so on, one every 3 cycles.
- Requester 1 sends 0011 while `out_ready` is held low for 5 cycles: `out_gray`=0010 and `out_id`=1 stay stable throughout. No new `ready` is issued until `out_ready` is high for one cycle.
- 260 back-to-back requester 0 transfers: `cnt0` saturates at 255 and `cnt1` stays 0.
- With `GRAY_SELFCHECK_EN` defined, sweep all 16 operands 0000–1111: `err` stays 0 and each `out_gray` equals b^(b>>1).

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code request arbiter: default operand
// width, FSM state encoding and requester IDs.
package gray_pkg;

  localparam int GRAY_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/gray_req_arbiter_if.sv
// Handshake bundle between the two producers, the consumer and the arbiter.
// The slave modport is the arbiter side, the master modport the environment side.
interface gray_req_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_bin;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_bin;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_gray;
  logic             out_id;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             err;

  modport slave (
    input  req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
    output req0_ready, req1_ready, out_valid, out_gray, out_id,
           busy, cnt0, cnt1, err
  );

  modport master (
    output req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
    input  req0_ready, req1_ready, out_valid, out_gray, out_id,
           busy, cnt0, cnt1, err
  );
endinterface

// File: rtl/bin2gray_4bit.sv
// Shared 4-bit binary-to-Gray converter (purely combinational).
module bin2gray_4bit (
  input  logic [3:0] i_bin,
  output logic [3:0] o_gray
);
  assign o_gray = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/gray2bin_4bit.sv
// 4-bit Gray-to-binary inverse, used only to cross-check the converter output.
module gray2bin_4bit (
  input  logic [3:0] i_gray,
  output logic [3:0] o_bin
);
  assign o_bin[3] = i_gray[3];
  assign o_bin[2] = o_bin[3] ^ i_gray[2];
  assign o_bin[1] = o_bin[2] ^ i_gray[1];
  assign o_bin[0] = o_bin[1] ^ i_gray[0];
endmodule

// File: rtl/gray_req_arbiter.sv
// Two-requester round-robin front end for the shared bin2gray_4bit converter.
// IDLE accepts one operand, CONV registers the Gray result, HOLD presents it
// until the consumer takes it. Per-requester saturating service counters.
// Optional macro GRAY_SELFCHECK_EN adds a gray2bin_4bit inverse whose
// mismatch against the latched operand sets the sticky err flag.
module gray_req_arbiter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  gray_req_arbiter_if.slave bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_out_gray;
  logic             r_id;
  logic             r_last;
  logic             r_out_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_idle;
  logic             w_gnt;
  logic             w_rdy0;
  logic             w_rdy1;
  logic [WIDTH-1:0] w_gray;

  // Ready is combinational but must read low while reset is applied.
  assign w_idle = (r_state == IDLE) && !rst;
  // Requester 1 wins when alone, or when both ask and requester 0 was served last.
  assign w_gnt  = bus.req1_valid & (~bus.req0_valid | (r_last == REQ0));
  assign w_rdy0 = w_idle & bus.req0_valid & (w_gnt == REQ0);
  assign w_rdy1 = w_idle & bus.req1_valid & (w_gnt == REQ1);

  bin2gray_4bit u_bin2gray (
    .i_bin  (r_bin),
    .o_gray (w_gray)
  );

  // Sequencer: accept, convert, hold until the consumer handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_out_gray  <= '0;
      r_id        <= REQ0;
      r_last      <= REQ1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rdy0 || w_rdy1) begin
            r_bin   <= w_rdy1 ? bus.req1_bin : bus.req0_bin;
            r_id    <= w_rdy1 ? REQ1 : REQ0;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_out_gray  <= w_gray;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            if (r_id == REQ1) begin
              if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + 1'b1;
            end else begin
              if (r_cnt0 != '1) r_cnt0 <= r_cnt0 + 1'b1;
            end
            r_last      <= r_id;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef GRAY_SELFCHECK_EN
  logic [WIDTH-1:0] w_back;
  logic             r_err;

  gray2bin_4bit u_gray2bin (
    .i_gray (w_gray),
    .o_bin  (w_back)
  );

  // Sticky flag: converter output failed to invert back to the operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == CONV && w_back != r_bin) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_gray   = r_out_gray;
  assign bus.out_id     = r_id;
  assign bus.busy       = r_busy;
  assign bus.cnt0       = r_cnt0;
  assign bus.cnt1       = r_cnt1;

endmodule
